// File: rtl/bit_deserializer_pkg.sv
// Shared types and helpers for the bit deserializer.
package deser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } deser_state_t;

    // Width of a counter that must hold values 0..width inclusive.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_deserializer_out_reg.sv
// Valid/ready holding register for completed words; reports dropped words.
module deser_out_reg
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             accept;

    // Load when empty or being drained this cycle; otherwise a new word is dropped.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_o = 1'b0;
        accept    = valid_q && ready_i;
        if (load_i && (!valid_q || accept)) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else begin
            overrun_o = load_i;
            if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    // Output register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler aligned on a frame marker.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_overrun,
    output logic             err_resync,
    input  logic             err_clr
);

    localparam int unsigned CW = cnt_w(WIDTH);

    deser_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             word_done;
    logic             resync_set;
    logic             overrun_pulse;
    logic             err_ovr_q, err_ovr_d;
    logic             err_rsy_q, err_rsy_d;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) begin
            return {cur[WIDTH-2:0], b};
        end else begin
            return {b, cur[WIDTH-1:1]};
        end
    endfunction

    // Next-state, counter and shifter; a word boundary (count 0) starts a fresh word.
    always_comb begin
        logic [CW-1:0] cnt_nxt;
        logic          fresh;
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        word_done  = 1'b0;
        resync_set = 1'b0;
        cnt_nxt    = '0;
        fresh      = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
        end else if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        sh_d    = shift_in('0, bit_in);
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    fresh      = frame_start || (cnt_q == '0);
                    resync_set = frame_start && (cnt_q != '0);
                    sh_d       = shift_in(fresh ? '0 : sh_q, bit_in);
                    cnt_nxt    = fresh ? CW'(1) : cnt_q + CW'(1);
                    if (cnt_nxt == CW'(WIDTH)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, counter and shift register state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk_i    (clk),
        .rst_ni   (rstb),
        .load_i   (word_done),
        .data_i   (sh_d),
        .ready_i  (out_ready),
        .data_o   (out_data),
        .valid_o  (out_valid),
        .overrun_o(overrun_pulse)
    );

    // Sticky flags: a set event outranks a simultaneous clear.
    always_comb begin
        err_ovr_d = overrun_pulse ? 1'b1 : (err_clr ? 1'b0 : err_ovr_q);
        err_rsy_d = resync_set ? 1'b1 : (err_clr ? 1'b0 : err_rsy_q);
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_ovr_q <= 1'b0;
            err_rsy_q <= 1'b0;
        end else begin
            err_ovr_q <= err_ovr_d;
            err_rsy_q <= err_rsy_d;
        end
    end

    assign err_overrun = err_ovr_q;
    assign err_resync  = err_rsy_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench: two DUTs (MSB-first and LSB-first) sharing stimulus.
module tb_bit_deserializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rstb, en, bi, bv, fs, rdy, clr;
    logic [W-1:0] od_m, od_l;
    logic ov_m, ov_l, eo_m, eo_l, er_m, er_l;

    int n_tests = 0;
    int n_fail  = 0;
    int n_words = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstb(rstb), .en(en), .bit_in(bi), .bit_valid(bv),
        .frame_start(fs), .out_data(od_m), .out_valid(ov_m), .out_ready(rdy),
        .err_overrun(eo_m), .err_resync(er_m), .err_clr(clr)
    );

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstb(rstb), .en(en), .bit_in(bi), .bit_valid(bv),
        .frame_start(fs), .out_data(od_l), .out_valid(ov_l), .out_ready(rdy),
        .err_overrun(eo_l), .err_resync(er_l), .err_clr(clr)
    );

    // Reference model: list of bits received since alignment.
    bit         m_aligned;
    bit         m_bits[$];
    bit         m_valid, m_ovr, m_rsy;
    bit [W-1:0] m_data_m, m_data_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_aligned = 0;
        m_bits.delete();
        m_valid = 0; m_ovr = 0; m_rsy = 0;
        m_data_m = '0; m_data_l = '0;
    endtask

    task automatic model_update();
        bit done, accept, ovr_set, rsy_set;
        bit [W-1:0] wm, wl;
        done = 0; ovr_set = 0; rsy_set = 0; wm = '0; wl = '0;
        accept = m_valid && rdy;
        if (!en) begin
            m_aligned = 0;
            m_bits.delete();
        end else if (bv) begin
            if (fs) begin
                if (m_aligned && m_bits.size() != 0) rsy_set = 1;
                m_bits.delete();
                m_bits.push_back(bi);
                m_aligned = 1;
            end else if (m_aligned) begin
                m_bits.push_back(bi);
            end
            if (m_aligned && m_bits.size() == W) begin
                done = 1;
                for (int i = 0; i < W; i++) begin
                    wm = (wm << 1) | W'(m_bits[i]);
                    wl = wl | (W'(m_bits[i]) << i);
                end
                m_bits.delete();
            end
        end
        if (done && (!m_valid || accept)) begin
            m_valid = 1; m_data_m = wm; m_data_l = wl;
        end else begin
            if (done) ovr_set = 1;
            if (accept) m_valid = 0;
        end
        m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_rsy = rsy_set ? 1'b1 : (clr ? 1'b0 : m_rsy);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("valid_m", ov_m, m_valid);
        chk("valid_l", ov_l, m_valid);
        chk("data_m", od_m, m_data_m);
        chk("data_l", od_l, m_data_l);
        chk("overrun", {eo_m, eo_l}, {m_ovr, m_ovr});
        chk("resync", {er_m, er_l}, {m_rsy, m_rsy});
        if (ov_m) n_words++;
    endtask

    task automatic idle(input int n);
        bv = 0; fs = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bits(input logic [7:0] seq, input int n, input bit framed);
        en = 1;
        for (int i = 0; i < n; i++) begin
            bv = 1; bi = seq[7-i]; fs = framed && (i == 0);
            step();
        end
        bv = 0; fs = 0;
    endtask

    typedef struct {
        logic [7:0] seq;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'b1010_0101, 8'hA5, 8'hA5};
        tbl[1] = '{8'b1101_0000, 8'hD0, 8'h0B};
        tbl[2] = '{8'b0011_1100, 8'h3C, 8'h3C};
        tbl[3] = '{8'b0000_0001, 8'h01, 8'h80};
        tbl[4] = '{8'b1111_0000, 8'hF0, 8'h0F};
        tbl[5] = '{8'b0001_0010, 8'h12, 8'h48};

        rstb = 0; en = 0; bi = 0; bv = 0; fs = 0; rdy = 1; clr = 0;
        model_reset();
        #2;
        chk("reset_valid", {ov_m, ov_l}, 2'b00);
        chk("reset_data", {od_m, od_l}, 16'h0);
        chk("reset_flags", {eo_m, er_m, eo_l, er_l}, 4'h0);
        @(negedge clk);
        rstb = 1;
        idle(2);

        // Table: framed words with ready high; one-cycle valid pulse after the last bit.
        en = 1;
        for (int v = 0; v < 6; v++) begin
            send_bits(tbl[v].seq, 8, 1'b1);
            chk("tbl_valid", ov_m, 1'b1);
            chk("tbl_data_m", od_m, tbl[v].exp_m);
            chk("tbl_data_l", od_l, tbl[v].exp_l);
            idle(1);
            chk("tbl_valid_drop", ov_m, 1'b0);
        end
        chk("tbl_flags", {eo_m, er_m}, 2'b00);

        // Overrun: ready low, two back-to-back words.
        en = 0; idle(1); en = 1;
        rdy = 0;
        send_bits(8'hA5, 8, 1'b1);
        send_bits(8'h3C, 8, 1'b0);
        chk("ovr_hold_data", od_m, 8'hA5);
        chk("ovr_flag", eo_m, 1'b1);
        rdy = 1; idle(1);
        chk("ovr_drained", ov_m, 1'b0);
        chk("ovr_data_kept", od_m, 8'hA5);
        clr = 1; idle(1); clr = 0;
        chk("ovr_cleared", eo_m, 1'b0);

        // Resync: partial word, then a framed full word.
        n_words = 0;
        send_bits(8'b1110_0000, 3, 1'b1);
        send_bits(8'h3C, 8, 1'b1);
        idle(1);
        chk("rsy_flag", er_m, 1'b1);
        chk("rsy_words", n_words, 1);
        chk("rsy_data", od_m, 8'h3C);
        clr = 1; idle(1); clr = 0;
        chk("rsy_cleared", er_m, 1'b0);
        send_bits(8'b1010_0000, 3, 1'b1);
        en = 1; bv = 1; fs = 1; bi = 1; clr = 1;
        step();
        clr = 0; bv = 0; fs = 0;
        chk("rsy_set_wins", er_m, 1'b1);
        en = 0; idle(1); en = 1;
        clr = 1; idle(1); clr = 0;

        // Enable drop discards a partial word; unframed bits in IDLE do nothing.
        n_words = 0;
        send_bits(8'b1011_0000, 4, 1'b1);
        en = 0; idle(2); en = 1;
        send_bits(8'h5A, 8, 1'b1);
        idle(1);
        chk("en_words", n_words, 1);
        chk("en_data", od_m, 8'h5A);
        en = 0; idle(1); en = 1;
        send_bits(8'hFF, 8, 1'b0);
        idle(2);
        chk("idle_no_word", n_words, 1);
        chk("idle_no_err", er_m, 1'b0);

        // Asynchronous reset with a held word, flags set and a partial word in flight.
        rdy = 0;
        send_bits(8'hA5, 8, 1'b1);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hF8, 5, 1'b0);
        chk("pre_rst_state", {ov_m, eo_m}, 2'b11);
        #2;
        rstb = 0;
        #1;
        chk("arst_valid", {ov_m, ov_l}, 2'b00);
        chk("arst_data", {od_m, od_l}, 16'h0);
        chk("arst_flags", {eo_m, er_m, eo_l, er_l}, 4'h0);
        model_reset();
        @(negedge clk);
        rstb = 1; rdy = 1;
        idle(1);
        n_words = 0;
        send_bits(8'hA5, 8, 1'b1);
        chk("post_rst_data", od_m, 8'hA5);
        chk("post_rst_valid", ov_m, 1'b1);
        idle(1);
        chk("post_rst_words", n_words, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            en  = ($urandom % 16) != 0;
            bv  = ($urandom % 4) != 0;
            fs  = ($urandom % 12) == 0;
            bi  = $urandom % 2;
            rdy = ($urandom % 3) != 0;
            clr = ($urandom % 20) == 0;
            model_update();
            @(posedge clk);
            #1;
            chk("rnd_valid", {ov_m, ov_l}, {m_valid, m_valid});
            chk("rnd_data_m", od_m, m_data_m);
            chk("rnd_data_l", od_l, m_data_l);
            chk("rnd_flags", {eo_m, er_m, eo_l, er_l}, {m_ovr, m_rsy, m_ovr, m_rsy});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
